// File: rtl/hazard_control.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control
// Brief    : RAW stall scoreboard, EX branch redirect and HALT drain sequencer
//            for the no-forwarding MIPS-Lite pipeline. Optional statistics
//            counters are built when HAZARD_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_control #(
    parameter int ADDRESSWIDTH = 32,
    parameter int REGADDRWIDTH = 5,
    parameter int STALL_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    idValid,
    input  logic [REGADDRWIDTH-1:0] idRs,
    input  logic [REGADDRWIDTH-1:0] idRt,
    input  logic                    idUsesRs,
    input  logic                    idUsesRt,
    input  logic                    idWritesReg,
    input  logic [REGADDRWIDTH-1:0] idDest,
    input  logic                    idIsHalt,
    input  logic                    exBranchResolved,
    input  logic [ADDRESSWIDTH-1:0] exBranchTarget,
    output logic                    hazardDetected,
    output logic                    branchTaken,
    output logic [ADDRESSWIDTH-1:0] branchAddress,
    output logic                    flushIfId,
    output logic                    flushIdEx,
    output logic                    haltSignal,
    output logic                    halted,
    output logic [31:0]             stallCycles,
    output logic [31:0]             flushCount
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [1:0] c_DRAIN_LOAD = 2'd3;

    state_t                                     r_state;
    state_t                                     w_stateNext;
    logic [1:0]                                 r_drainCnt;
    logic [1:0]                                 w_drainCntNext;
    logic [STALL_DEPTH-1:0]                     r_slotValid;
    logic [STALL_DEPTH-1:0][REGADDRWIDTH-1:0]   r_slotDest;
    logic [STALL_DEPTH-1:0]                     w_hitRs;
    logic [STALL_DEPTH-1:0]                     w_hitRt;
    logic                                       w_matchRs;
    logic                                       w_matchRt;
    logic                                       w_slot0Load;

    genvar gi;
    generate
        for (gi = 0; gi < STALL_DEPTH; gi++) begin : g_match
            assign w_hitRs[gi] = r_slotValid[gi] & (r_slotDest[gi] == idRs);
            assign w_hitRt[gi] = r_slotValid[gi] & (r_slotDest[gi] == idRt);
        end
    endgenerate

    // R0 is hardwired, so it can never be the subject of a RAW hazard.
    assign w_matchRs = idUsesRs & (idRs != '0) & (|w_hitRs);
    assign w_matchRt = idUsesRt & (idRt != '0) & (|w_hitRt);

    assign branchTaken    = exBranchResolved & (r_state != S_HALTED);
    assign branchAddress  = exBranchTarget;
    assign hazardDetected = (r_state == S_RUN) & idValid & ~branchTaken
                          & (w_matchRs | w_matchRt);
    assign flushIdEx      = branchTaken;
    assign flushIfId      = branchTaken | (r_state == S_DRAIN);
    assign haltSignal     = (r_state != S_RUN);
    assign halted         = (r_state == S_HALTED);

    // Stalled or squashed instructions enter ID/EX as bubbles and own no slot.
    assign w_slot0Load = idValid & idWritesReg & (idDest != '0)
                       & ~hazardDetected & ~flushIdEx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slotValid <= '0;
            r_slotDest  <= '0;
        end else begin
            r_slotValid[0] <= w_slot0Load;
            r_slotDest[0]  <= w_slot0Load ? idDest : '0;
            for (int i = 1; i < STALL_DEPTH; i++) begin
                r_slotValid[i] <= r_slotValid[i-1];
                r_slotDest[i]  <= r_slotDest[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_drainCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_drainCnt <= w_drainCntNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_drainCntNext = r_drainCnt;
        case (r_state)
            S_RUN: begin
                if (idValid & idIsHalt & ~hazardDetected & ~branchTaken) begin
                    w_stateNext    = S_DRAIN;
                    w_drainCntNext = c_DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                // Three drain cycles cover the instructions left in EX, MEM and WB.
                w_drainCntNext = r_drainCnt - 2'd1;
                if (w_drainCntNext == 2'd0) begin
                    w_stateNext = S_HALTED;
                end
            end
            S_HALTED: begin
                w_stateNext = S_HALTED;
            end
            default: begin
                w_stateNext    = S_RUN;
                w_drainCntNext = '0;
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stallCycles;
    logic [31:0] r_flushCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else if (r_state != S_HALTED) begin
            if (hazardDetected && (r_stallCycles != 32'hFFFF_FFFF)) begin
                r_stallCycles <= r_stallCycles + 32'd1;
            end
            if (branchTaken && (r_flushCount != 32'hFFFF_FFFF)) begin
                r_flushCount <= r_flushCount + 32'd1;
            end
        end
    end

    assign stallCycles = r_stallCycles;
    assign flushCount  = r_flushCount;
`else
    assign stallCycles = '0;
    assign flushCount  = '0;
`endif

endmodule
`default_nettype wire
